// File: rtl/alu_ctrl_mem_unit.sv
// Execute/memory slice of the 24-bit single-issue CPU. One register stage captures the
// instruction fields, operands and decoded controls; ALU, data memory read, writeback select
// and branch decision are combinational from that stage during the following cycle.
module alu_ctrl_mem_unit #(
    parameter int unsigned DW        = 24,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [4:0]    op,
    input  logic [1:0]    rd,
    input  logic [1:0]    rt,
    input  logic [11:0]   offset,
    input  logic [DW-1:0] rs_data,
    input  logic [DW-1:0] rt_data,
    input  logic          carry_in,
    output logic          reg_write,
    output logic [1:0]    write_reg,
    output logic [DW-1:0] wb_data,
    output logic [DW-1:0] alu_result,
    output logic [2:0]    flags,
    output logic          branch_taken,
    output logic [DW-1:0] mem_rdata
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {
        AluAdd   = 3'd0,
        AluSub   = 3'd1,
        AluAnd   = 3'd2,
        AluOr    = 3'd3,
        AluXor   = 3'd4,
        AluSlt   = 3'd5,
        AluAdc   = 3'd6,
        AluPassB = 3'd7
    } alu_op_e;

    logic          valid_d, valid_q;
    logic          reg_dst_d, reg_dst_q;
    logic          reg_write_d, reg_write_q;
    logic          alu_src_d, alu_src_q;
    alu_op_e       alu_op_d, alu_op_q;
    logic          branch_d, branch_q;
    logic          bne_d, bne_q;
    logic          mem_write_d, mem_write_q;
    logic          mem_read_d, mem_read_q;
    logic          mem_to_reg_d, mem_to_reg_q;
    logic [1:0]    rd_q, rt_q;
    logic [11:0]   offset_q;
    logic [DW-1:0] rs_q, rtd_q;
    logic          cin_q;

    logic [DW-1:0] mem_q [MEM_DEPTH];
    logic [DW-1:0] alu_b;
    logic [DW-1:0] res;
    logic          c_flag;
    logic [AW-1:0] addr;

    // Opcode decode; undefined opcodes fall through to the all-zero NOP controls.
    always_comb begin
        valid_d      = 1'b1;
        reg_dst_d    = 1'b0;
        reg_write_d  = 1'b0;
        alu_src_d    = 1'b0;
        alu_op_d     = AluAdd;
        branch_d     = 1'b0;
        bne_d        = 1'b0;
        mem_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        mem_to_reg_d = 1'b0;
        case (op)
            5'b00010: begin reg_dst_d = 1'b1; reg_write_d = 1'b1; end
            5'b00011: begin reg_dst_d = 1'b1; reg_write_d = 1'b1; alu_src_d = 1'b1; end
            5'b00100: begin alu_op_d = AluSub; branch_d = 1'b1; bne_d = 1'b1; end
            5'b00101: begin alu_op_d = AluSub; branch_d = 1'b1; end
            5'b00110: begin
                reg_write_d  = 1'b1;
                alu_src_d    = 1'b1;
                mem_read_d   = 1'b1;
                mem_to_reg_d = 1'b1;
            end
            5'b00111: begin alu_src_d = 1'b1; mem_write_d = 1'b1; end
            5'b01000: begin reg_dst_d = 1'b1; reg_write_d = 1'b1; alu_op_d = AluSub; end
            5'b01001: begin reg_dst_d = 1'b1; reg_write_d = 1'b1; alu_op_d = AluAnd; end
            5'b01010: begin reg_dst_d = 1'b1; reg_write_d = 1'b1; alu_op_d = AluOr; end
            5'b01011: begin reg_dst_d = 1'b1; reg_write_d = 1'b1; alu_op_d = AluXor; end
            5'b01100: begin reg_dst_d = 1'b1; reg_write_d = 1'b1; alu_op_d = AluSlt; end
            5'b01101: begin reg_dst_d = 1'b1; reg_write_d = 1'b1; alu_op_d = AluAdc; end
            5'b01110: begin
                reg_dst_d   = 1'b1;
                reg_write_d = 1'b1;
                alu_src_d   = 1'b1;
                alu_op_d    = AluPassB;
            end
            default: valid_d = 1'b0;
        endcase
    end

    // Stage register; a NOP also clears the captured fields so its outputs match reset.
    always_ff @(posedge clock) begin
        if (reset || !valid_d) begin
            valid_q      <= 1'b0;
            reg_dst_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            alu_src_q    <= 1'b0;
            alu_op_q     <= AluAdd;
            branch_q     <= 1'b0;
            bne_q        <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_to_reg_q <= 1'b0;
            rd_q         <= '0;
            rt_q         <= '0;
            offset_q     <= '0;
            rs_q         <= '0;
            rtd_q        <= '0;
            cin_q        <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            reg_dst_q    <= reg_dst_d;
            reg_write_q  <= reg_write_d;
            alu_src_q    <= alu_src_d;
            alu_op_q     <= alu_op_d;
            branch_q     <= branch_d;
            bne_q        <= bne_d;
            mem_write_q  <= mem_write_d;
            mem_read_q   <= mem_read_d;
            mem_to_reg_q <= mem_to_reg_d;
            rd_q         <= rd;
            rt_q         <= rt;
            offset_q     <= offset;
            rs_q         <= rs_data;
            rtd_q        <= rt_data;
            cin_q        <= carry_in;
        end
    end

    assign alu_b = alu_src_q ? {{(DW-12){1'b0}}, offset_q} : rtd_q;

    // ALU; C is carry-out for ADD/ADC and no-borrow (A >= B) for SUB.
    always_comb begin
        res    = '0;
        c_flag = 1'b0;
        case (alu_op_q)
            AluAdd:   {c_flag, res} = {1'b0, rs_q} + {1'b0, alu_b};
            AluSub: begin
                res    = rs_q - alu_b;
                c_flag = (rs_q >= alu_b);
            end
            AluAnd:   res = rs_q & alu_b;
            AluOr:    res = rs_q | alu_b;
            AluXor:   res = rs_q ^ alu_b;
            AluSlt:   res = {{(DW-1){1'b0}}, ($signed(rs_q) < $signed(alu_b))};
            AluAdc:   {c_flag, res} = {1'b0, rs_q} + {1'b0, alu_b} + {{DW{1'b0}}, cin_q};
            AluPassB: res = alu_b;
            default:  res = '0;
        endcase
    end

    assign alu_result   = valid_q ? res : '0;
    // Gated so an idle stage reports no Z flag.
    assign flags        = valid_q ? {c_flag, res[DW-1], (res == '0)} : 3'b000;
    assign branch_taken = branch_q & (bne_q ? ~flags[0] : flags[0]);
    assign reg_write    = reg_write_q;
    assign write_reg    = reg_dst_q ? rd_q : rt_q;
    assign addr         = alu_result[AW-1:0];
    assign mem_rdata    = mem_read_q ? mem_q[addr] : '0;
    assign wb_data      = mem_to_reg_q ? mem_rdata : alu_result;

    // Store commits on the edge ending the SW cycle unless reset is asserted on that edge.
    always_ff @(posedge clock) begin
        if (mem_write_q && !reset) begin
            mem_q[addr] <= rtd_q;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_mem_unit.sv
// Directed bench for alu_ctrl_mem_unit: each task drives one scenario and checks outputs
// one cycle after issue against hand-computed values.
module tb_alu_ctrl_mem_unit;

    logic        clock;
    logic        reset;
    logic [4:0]  op;
    logic [1:0]  rd;
    logic [1:0]  rt;
    logic [11:0] offset;
    logic [23:0] rs_data;
    logic [23:0] rt_data;
    logic        carry_in;
    logic        reg_write;
    logic [1:0]  write_reg;
    logic [23:0] wb_data;
    logic [23:0] alu_result;
    logic [2:0]  flags;
    logic        branch_taken;
    logic [23:0] mem_rdata;

    int checks = 0;
    int failures = 0;

    alu_ctrl_mem_unit #(.DW(24), .MEM_DEPTH(256)) dut (
        .clock       (clock),
        .reset       (reset),
        .op          (op),
        .rd          (rd),
        .rt          (rt),
        .offset      (offset),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .carry_in    (carry_in),
        .reg_write   (reg_write),
        .write_reg   (write_reg),
        .wb_data     (wb_data),
        .alu_result  (alu_result),
        .flags       (flags),
        .branch_taken(branch_taken),
        .mem_rdata   (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Apply one instruction, clock it into the stage, and settle past the edge.
    task automatic issue(input logic [4:0] o, input logic [1:0] d, input logic [1:0] t,
                         input logic [11:0] off, input logic [23:0] a, input logic [23:0] b,
                         input logic ci);
        op = o; rd = d; rt = t; offset = off; rs_data = a; rt_data = b; carry_in = ci;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        issue(5'b00010, 2'd1, 2'd2, 12'h0, 24'd5, 24'd3, 1'b0);
        issue(5'b00010, 2'd1, 2'd2, 12'h0, 24'd5, 24'd3, 1'b0);
        checks++;
        if ({reg_write, write_reg, branch_taken, flags} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl got rw=%0b wr=%0d bt=%0b fl=%b want all 0",
                     reg_write, write_reg, branch_taken, flags);
        end
        checks++;
        if ({wb_data, alu_result, mem_rdata} !== 72'b0) begin
            failures++;
            $display("FAIL reset_data got wb=%h alu=%h mr=%h want 0", wb_data, alu_result,
                     mem_rdata);
        end
        reset = 1'b0;
    endtask

    task automatic test_addi();
        issue(5'b00011, 2'd1, 2'd0, 12'd1, 24'd5, 24'd0, 1'b0);
        checks++;
        if ({reg_write, write_reg, wb_data, flags} !== {1'b1, 2'd1, 24'd6, 3'b000}) begin
            failures++;
            $display("FAIL addi got rw=%0b wr=%0d wb=%h fl=%b want 1 1 000006 000",
                     reg_write, write_reg, wb_data, flags);
        end
    endtask

    task automatic test_alu();
        issue(5'b00010, 2'd3, 2'd1, 12'h0, 24'hFFFFFF, 24'd1, 1'b0);
        checks++;
        if ({alu_result, flags, write_reg} !== {24'h0, 3'b101, 2'd3}) begin
            failures++;
            $display("FAIL add_wrap got alu=%h fl=%b wr=%0d want 000000 101 3", alu_result,
                     flags, write_reg);
        end
        issue(5'b01100, 2'd2, 2'd1, 12'h0, 24'h800000, 24'd1, 1'b0);
        checks++;
        if ({alu_result, flags} !== {24'd1, 3'b000}) begin
            failures++;
            $display("FAIL slt got alu=%h fl=%b want 000001 000", alu_result, flags);
        end
        issue(5'b01000, 2'd1, 2'd1, 12'h0, 24'd3, 24'd5, 1'b0);
        checks++;
        if ({alu_result, flags} !== {24'hFFFFFE, 3'b010}) begin
            failures++;
            $display("FAIL sub_borrow got alu=%h fl=%b want fffffe 010", alu_result, flags);
        end
        issue(5'b01101, 2'd1, 2'd1, 12'h0, 24'hFFFFFF, 24'd0, 1'b1);
        checks++;
        if ({alu_result, flags} !== {24'h0, 3'b101}) begin
            failures++;
            $display("FAIL adc_carry got alu=%h fl=%b want 000000 101", alu_result, flags);
        end
        issue(5'b01011, 2'd1, 2'd1, 12'h0, 24'hF0F0F0, 24'hFF00FF, 1'b0);
        checks++;
        if ({alu_result, flags} !== {24'h0FF00F, 3'b000}) begin
            failures++;
            $display("FAIL xor got alu=%h fl=%b want 0ff00f 000", alu_result, flags);
        end
        issue(5'b01110, 2'd2, 2'd0, 12'hABC, 24'h123456, 24'h0, 1'b0);
        checks++;
        if ({wb_data, write_reg, reg_write} !== {24'h000ABC, 2'd2, 1'b1}) begin
            failures++;
            $display("FAIL li got wb=%h wr=%0d rw=%0b want 000abc 2 1", wb_data, write_reg,
                     reg_write);
        end
    endtask

    task automatic test_mem();
        issue(5'b00111, 2'd0, 2'd1, 12'd4, 24'd0, 24'hABCDEF, 1'b0);
        checks++;
        if ({reg_write, mem_rdata} !== {1'b0, 24'h0}) begin
            failures++;
            $display("FAIL sw_cycle got rw=%0b mr=%h want 0 000000", reg_write, mem_rdata);
        end
        issue(5'b00110, 2'd0, 2'd2, 12'd4, 24'd0, 24'd0, 1'b0);
        checks++;
        if ({wb_data, write_reg, reg_write} !== {24'hABCDEF, 2'd2, 1'b1}) begin
            failures++;
            $display("FAIL lw got wb=%h wr=%0d rw=%0b want abcdef 2 1", wb_data, write_reg,
                     reg_write);
        end
        issue(5'b00110, 2'd0, 2'd1, 12'd4, 24'd256, 24'd0, 1'b0);
        checks++;
        if ({mem_rdata, write_reg} !== {24'hABCDEF, 2'd1}) begin
            failures++;
            $display("FAIL lw_alias got mr=%h wr=%0d want abcdef 1", mem_rdata, write_reg);
        end
    endtask

    task automatic test_back_to_back();
        issue(5'b00111, 2'd0, 2'd1, 12'd10, 24'd0, 24'h123456, 1'b0);
        issue(5'b00111, 2'd0, 2'd1, 12'd11, 24'd0, 24'h654321, 1'b0);
        issue(5'b00110, 2'd0, 2'd3, 12'd10, 24'd0, 24'd0, 1'b0);
        checks++;
        if (wb_data !== 24'h123456) begin
            failures++;
            $display("FAIL b2b_lw10 got wb=%h want 123456", wb_data);
        end
        issue(5'b00110, 2'd0, 2'd3, 12'd11, 24'd0, 24'd0, 1'b0);
        checks++;
        if (wb_data !== 24'h654321) begin
            failures++;
            $display("FAIL b2b_lw11 got wb=%h want 654321", wb_data);
        end
    endtask

    task automatic test_branch();
        issue(5'b00100, 2'd0, 2'd1, 12'h0, 24'd7, 24'd7, 1'b0);
        checks++;
        if ({branch_taken, reg_write} !== 2'b00) begin
            failures++;
            $display("FAIL bne_eq got bt=%0b rw=%0b want 0 0", branch_taken, reg_write);
        end
        issue(5'b00100, 2'd0, 2'd1, 12'h0, 24'd7, 24'd3, 1'b0);
        checks++;
        if ({branch_taken, reg_write} !== 2'b10) begin
            failures++;
            $display("FAIL bne_ne got bt=%0b rw=%0b want 1 0", branch_taken, reg_write);
        end
        issue(5'b00101, 2'd0, 2'd1, 12'h0, 24'd7, 24'd7, 1'b0);
        checks++;
        if ({branch_taken, reg_write} !== 2'b10) begin
            failures++;
            $display("FAIL beq_eq got bt=%0b rw=%0b want 1 0", branch_taken, reg_write);
        end
        issue(5'b00101, 2'd0, 2'd1, 12'h0, 24'd7, 24'd3, 1'b0);
        checks++;
        if ({branch_taken, reg_write} !== 2'b00) begin
            failures++;
            $display("FAIL beq_ne got bt=%0b rw=%0b want 0 0", branch_taken, reg_write);
        end
        issue(5'b01000, 2'd0, 2'd1, 12'h0, 24'd7, 24'd7, 1'b0);
        checks++;
        if (branch_taken !== 1'b0) begin
            failures++;
            $display("FAIL sub_nobranch got bt=%0b want 0", branch_taken);
        end
    endtask

    task automatic test_reset_store();
        // Word 4 holds abcdef; a reset on the store's commit edge must suppress it.
        issue(5'b00111, 2'd0, 2'd1, 12'd4, 24'd0, 24'h555555, 1'b0);
        reset = 1'b1;
        issue(5'b00000, 2'd0, 2'd0, 12'h0, 24'd0, 24'd0, 1'b0);
        reset = 1'b0;
        issue(5'b00110, 2'd0, 2'd2, 12'd4, 24'd0, 24'd0, 1'b0);
        checks++;
        if (wb_data !== 24'hABCDEF) begin
            failures++;
            $display("FAIL reset_store got wb=%h want abcdef", wb_data);
        end
    endtask

    task automatic test_undef();
        issue(5'b11111, 2'd1, 2'd0, 12'd4, 24'd5, 24'd3, 1'b1);
        checks++;
        if ({reg_write, write_reg, branch_taken, flags} !== 7'b0 ||
            {wb_data, alu_result, mem_rdata} !== 72'b0) begin
            failures++;
            $display("FAIL undef_op got rw=%0b wr=%0d bt=%0b fl=%b wb=%h alu=%h mr=%h want 0",
                     reg_write, write_reg, branch_taken, flags, wb_data, alu_result, mem_rdata);
        end
    endtask

    initial begin
        reset = 1'b1;
        op = '0; rd = '0; rt = '0; offset = '0; rs_data = '0; rt_data = '0; carry_in = 1'b0;
        test_reset();
        test_addi();
        test_alu();
        test_mem();
        test_back_to_back();
        test_branch();
        test_reset_store();
        test_undef();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
